// File: rtl/player_draw_pkg.sv
// Shared constants for the player sprite draw path: geometry, widths, colours and sprite pattern.
package player_draw_pkg;

    localparam int unsigned SPRITE_W      = 10;
    localparam int unsigned SPRITE_H      = 10;
    localparam int unsigned SPRITE_PIXELS = SPRITE_W * SPRITE_H;
    localparam int unsigned SCREEN_W      = 160;
    localparam int unsigned SCREEN_H      = 120;
    localparam int unsigned NUM_LANES     = 4;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned XCALC_W  = 9;
    localparam int unsigned YCALC_W  = 8;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned LANE_W   = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned ADDR_W   = 7;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COLOUR_BLUE  = 3'b001;
    localparam logic [COLOUR_W-1:0] COLOUR_GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

    // Sprite image: black corners, green border, white body.
    function automatic logic [COLOUR_W-1:0] sprite_pixel(input logic [ADDR_W-1:0] addr);
        int unsigned a;
        int unsigned col;
        int unsigned row;
        logic        edge_col;
        logic        edge_row;
        a        = 32'(addr);
        col      = a % SPRITE_W;
        row      = a / SPRITE_W;
        edge_col = (col == 0) || (col == SPRITE_W - 1);
        edge_row = (row == 0) || (row == SPRITE_H - 1);
        if (edge_col && edge_row) begin
            return COLOUR_BLACK;
        end else if (edge_col || edge_row) begin
            return COLOUR_GREEN;
        end
        return COLOUR_WHITE;
    endfunction

endpackage

// File: rtl/player_sprite_rom.sv
// 100x3 player sprite ROM with one-cycle synchronous read, addressed by dy*10+dx.
module player_sprite_rom
    import player_draw_pkg::*;
(
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr,
    output logic [COLOUR_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= sprite_pixel(addr);
    end

endmodule

// File: rtl/player_draw_datapath.sv
// Player lane register and 10x10 erase/draw pixel walker feeding the VGA adapter.
// Define PLAYER_SPRITE_ROM_EN to take draw colour from player_sprite_rom (adds one stage).
module player_draw_datapath
    import player_draw_pkg::*;
#(
    parameter int unsigned         X_BASE        = 40,
    parameter int unsigned         LANE_STEP     = 25,
    parameter int unsigned         Y_POS         = 105,
    parameter logic [COLOUR_W-1:0] PLAYER_COLOUR = 3'b010,
    parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ld_pos1,
    input  logic                ld_pos2,
    input  logic                ld_pos3,
    input  logic                ld_pos4,
    input  logic                inEraseState,
    input  logic                inDrawState,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                done
);

    logic [LANE_W-1:0] lane;
    logic [CNT_W-1:0]  dx;
    logic [CNT_W-1:0]  dy;
    logic              erase_c;
    logic              active_c;
    logic              last_c;
    logic [X_W-1:0]    x_c;
    logic [Y_W-1:0]    y_c;

    // Lane select: lowest-index load wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lane <= '0;
        end else if (ld_pos1) begin
            lane <= LANE_W'(0);
        end else if (ld_pos2) begin
            lane <= LANE_W'(1);
        end else if (ld_pos3) begin
            lane <= LANE_W'(2);
        end else if (ld_pos4) begin
            lane <= LANE_W'(3);
        end
    end

    always_comb begin
        erase_c  = inEraseState;
        active_c = inEraseState || inDrawState;
        last_c   = (dx == CNT_W'(SPRITE_W - 1)) && (dy == CNT_W'(SPRITE_H - 1));
        x_c      = X_W'(XCALC_W'(X_BASE) + XCALC_W'(lane) * XCALC_W'(LANE_STEP) + XCALC_W'(dx));
        y_c      = Y_W'(YCALC_W'(Y_POS) + YCALC_W'(dy));
    end

    // Pixel walker holds its position while idle, mirroring the FSM's draw counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (active_c) begin
            if (dx == CNT_W'(SPRITE_W - 1)) begin
                dx <= '0;
                dy <= (dy == CNT_W'(SPRITE_H - 1)) ? '0 : dy + CNT_W'(1);
            end else begin
                dx <= dx + CNT_W'(1);
            end
        end
    end

`ifdef PLAYER_SPRITE_ROM_EN
    logic [COLOUR_W-1:0] rom_data;
    logic [X_W-1:0]      x_s1;
    logic [Y_W-1:0]      y_s1;
    logic                plot_s1;
    logic                done_s1;
    logic                erase_s1;

    player_sprite_rom u_rom (
        .clk  (clk),
        .addr (ADDR_W'(ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx))),
        .data (rom_data)
    );

    // Stage 1 aligns coordinates with the ROM read; stage 2 drives the adapter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_s1     <= '0;
            y_s1     <= '0;
            plot_s1  <= 1'b0;
            done_s1  <= 1'b0;
            erase_s1 <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            done     <= 1'b0;
        end else begin
            x_s1     <= x_c;
            y_s1     <= y_c;
            plot_s1  <= active_c;
            done_s1  <= active_c && last_c;
            erase_s1 <= erase_c;
            x        <= x_s1;
            y        <= y_s1;
            colour   <= erase_s1 ? BG_COLOUR : rom_data;
            plot     <= plot_s1;
            done     <= done_s1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            done   <= 1'b0;
        end else begin
            x      <= x_c;
            y      <= y_c;
            colour <= erase_c ? BG_COLOUR : PLAYER_COLOUR;
            plot   <= active_c;
            done   <= active_c && last_c;
        end
    end
`endif

endmodule

// File: tb/tb_player_draw_datapath.sv
// Directed bench for player_draw_datapath in its default (solid colour) build.
module tb_player_draw_datapath;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ld_pos1, ld_pos2, ld_pos3, ld_pos4;
    logic       inEraseState, inDrawState;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    player_draw_datapath dut (
        .clk          (clk),
        .resetn       (resetn),
        .ld_pos1      (ld_pos1),
        .ld_pos2      (ld_pos2),
        .ld_pos3      (ld_pos3),
        .ld_pos4      (ld_pos4),
        .inEraseState (inEraseState),
        .inDrawState  (inDrawState),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .done         (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ld_pos1 = 1'b0; ld_pos2 = 1'b0; ld_pos3 = 1'b0; ld_pos4 = 1'b0;
        inEraseState = 1'b0; inDrawState = 1'b0;
    endtask

    // One idle (or load) cycle: nothing must be plotted.
    task automatic idle_cycle(input string nm);
        step();
        total++;
        if (plot !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle: plot=%b done=%b required plot=0 done=0", nm, plot, done);
        end
    endtask

    task automatic pulse_lane(input int n, input string nm);
        clear_inputs();
        case (n)
            1: ld_pos1 = 1'b1;
            2: ld_pos2 = 1'b1;
            3: ld_pos3 = 1'b1;
            default: ld_pos4 = 1'b1;
        endcase
        idle_cycle(nm);
        clear_inputs();
    endtask

    // Drive an erase/draw run over pixels start..start+count-1 and check each output pixel.
    task automatic run_window(input bit er, input bit dr, input int lane_e, input logic [2:0] col_e,
                              input int start, input int count, input string nm);
        int plots = 0;
        int dones = 0;
        logic [7:0] ex;
        logic [6:0] ey;
        logic       ed;
        inEraseState = er;
        inDrawState  = dr;
        for (int i = 0; i < count; i++) begin
            int idx;
            step();
            idx = start + i;
            ex  = 8'(40 + lane_e * 25 + idx % 10);
            ey  = 7'(105 + idx / 10);
            ed  = (idx == 99);
            if (plot === 1'b1) plots++;
            if (done === 1'b1) dones++;
            total++;
            if (x !== ex || y !== ey || colour !== col_e || plot !== 1'b1 || done !== ed) begin
                bad++;
                $display("FAIL %s pixel %0d: x=%0d y=%0d colour=%b plot=%b done=%b required x=%0d y=%0d colour=%b plot=1 done=%b",
                         nm, idx, x, y, colour, plot, done, ex, ey, col_e, ed);
            end
        end
        clear_inputs();
        total++;
        if (plots !== count || dones !== ((start + count == 100) ? 1 : 0)) begin
            bad++;
            $display("FAIL %s counts: plots=%0d dones=%0d required plots=%0d dones=%0d",
                     nm, plots, dones, count, (start + count == 100) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn      = 1'b0;
        inDrawState = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || plot !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset cycle %0d: x=%0d y=%0d colour=%b plot=%b done=%b required all 0",
                         i, x, y, colour, plot, done);
            end
        end
        clear_inputs();
        resetn = 1'b1;
        idle_cycle("reset_release");
    endtask

    task automatic test_draw_lane0();
        pulse_lane(1, "lane0_load");
        run_window(1'b0, 1'b1, 0, 3'b010, 0, 100, "draw_lane0");
        idle_cycle("draw_lane0_after");
    endtask

    task automatic test_lane_change();
        run_window(1'b1, 1'b0, 0, 3'b000, 0, 100, "erase_old_lane");
        pulse_lane(2, "lane1_load");
        run_window(1'b0, 1'b1, 1, 3'b010, 0, 100, "draw_lane1");
        idle_cycle("lane_change_after");
    endtask

    task automatic test_lane3_bounds();
        pulse_lane(4, "lane3_load");
        run_window(1'b0, 1'b1, 3, 3'b010, 0, 100, "draw_lane3");
    endtask

    task automatic test_priority();
        clear_inputs();
        ld_pos3 = 1'b1;
        ld_pos4 = 1'b1;
        idle_cycle("prio_load");
        clear_inputs();
        run_window(1'b0, 1'b1, 2, 3'b010, 0, 100, "draw_prio_lane2");
    endtask

    task automatic test_simultaneous();
        run_window(1'b1, 1'b1, 2, 3'b000, 0, 100, "erase_and_draw");
    endtask

    task automatic test_back_to_back();
        run_window(1'b1, 1'b0, 2, 3'b000, 0, 100, "b2b_erase");
        pulse_lane(1, "b2b_pos");
        run_window(1'b0, 1'b1, 0, 3'b010, 0, 100, "b2b_draw");
    endtask

    task automatic test_hold();
        run_window(1'b0, 1'b1, 0, 3'b010, 0, 5, "hold_first");
        for (int i = 0; i < 3; i++) idle_cycle("hold_gap");
        run_window(1'b0, 1'b1, 0, 3'b010, 5, 95, "hold_rest");
    endtask

    task automatic test_reset_mid_draw();
        pulse_lane(2, "mid_lane1_load");
        run_window(1'b0, 1'b1, 1, 3'b010, 0, 37, "mid_partial");
        resetn      = 1'b0;
        inDrawState = 1'b1;
        step();
        total++;
        if (plot !== 1'b0 || done !== 1'b0 || x !== 8'd0 || y !== 7'd0) begin
            bad++;
            $display("FAIL mid_reset: x=%0d y=%0d plot=%b done=%b required 0 0 0 0", x, y, plot, done);
        end
        resetn = 1'b1;
        run_window(1'b0, 1'b1, 0, 3'b010, 0, 100, "mid_fresh_draw");
    endtask

    initial begin
        test_reset();
        test_draw_lane0();
        test_lane_change();
        test_lane3_bounds();
        test_priority();
        test_simultaneous();
        test_back_to_back();
        test_hold();
        test_reset_mid_draw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
